shift_sequencer: RTL and testbench



---
 rtl/shift_seq_pkg.sv | 16 +
 rtl/shift_seq_shadow.sv | 48 ++++
 rtl/shift_sequencer.sv | 146 ++++++++++++++
 tb/tb_shift_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Purpose: shared state encoding and default sizes for the shift sequencer slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_seq_pkg;

    localparam int WIDTH_DEF = 8;   // data width of the downstream shifter
    localparam int CNT_W_DEF = 4;   // width of Count and the remaining-shift counter

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/shift_seq_shadow.sv
// Purpose: shadow copy of the downstream shifter plus end-of-command comparator.
// Latency: shadow tracks the shifter edge for edge; mismatch flag rises the cycle after check.
// Backpressure: none; follows the sequencer's registered pin drive.
//
// Ports: clk/reset (sync, active-high); load_n/shift_right/fill/load_val mirror the
// shifter pins; check marks the cycle where sh_q is final; clear is an accepted
// start; mismatch is the sticky failure flag.
module shift_seq_shadow #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_n,
    input  logic             shift_right,
    input  logic             fill,
    input  logic [WIDTH-1:0] load_val,
    input  logic             check,
    input  logic             clear,
    input  logic [WIDTH-1:0] sh_q,
    output logic             mismatch
);

    logic [WIDTH-1:0] shadow_q;

    // Same update rule as the shifter: load has priority over shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '0;
        end else if (!load_n) begin
            shadow_q <= load_val;
        end else if (shift_right) begin
            shadow_q <= {fill, shadow_q[WIDTH-1:1]};
        end
    end

    // A detected difference wins over a same-cycle clear so a back-to-back
    // command cannot hide the failure of the one just finishing.
    always_ff @(posedge clk) begin
        if (reset) begin
            mismatch <= 1'b0;
        end else if (check && (shadow_q != sh_q)) begin
            mismatch <= 1'b1;
        end else if (clear) begin
            mismatch <= 1'b0;
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Purpose: sequences load + N right shifts on the downstream shifter, pulses Done when final.
// Latency: Start in cycle 0 -> LOAD cycle 1 -> SHIFT cycles 2..N+1 -> Done cycle N+2.
// Backpressure: none; Start is only accepted in IDLE/DONE and dropped otherwise.
//
// Ports: Clk, Reset (sync, active-high); Start/Load_Val/Count/Arith command inputs;
// Sh_Q shifter feedback; Sh_Load_Val/Sh_Load_n/Sh_ShiftRight/Sh_ASR shifter drive;
// Busy, Done, Remaining status; Mismatch shadow-check flag.
// Optional: define SHIFT_SEQ_SHADOW_CHECK_EN to add the shadow register check;
// otherwise Sh_Q is unused and Mismatch is tied low.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Load_Val,
    input  logic [CNT_W-1:0] Count,
    input  logic             Arith,
    input  logic [WIDTH-1:0] Sh_Q,
    output logic [WIDTH-1:0] Sh_Load_Val,
    output logic             Sh_Load_n,
    output logic             Sh_ShiftRight,
    output logic             Sh_ASR,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Remaining,
    output logic             Mismatch
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q;
    logic             arith_q;
    logic             start_acc;
    logic [CNT_W-1:0] count_sat;

    logic [WIDTH-1:0] load_val_d;
    logic             load_n_d, shift_right_d, asr_d, busy_d, done_d;

    assign start_acc = Start && ((state_q == IDLE) || (state_q == DONE));
    assign count_sat = (Count > CNT_MAX) ? CNT_MAX : Count;
    assign Remaining = rem_q;

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. rem_q holds the shifts still to issue, including the
    // one issued in the current SHIFT cycle, so 1 means this is the last.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (Start) state_d = LOAD;
            LOAD:    state_d = (rem_q != '0) ? SHIFT : DONE;
            SHIFT:   if (rem_q == CNT_ONE) state_d = DONE;
            DONE:    state_d = Start ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic, decoded from the next state so the pins are registered
    // and line up with the state they belong to. Sh_Load_Val holds the
    // captured operand after LOAD, which also supplies the sign bit for ASR.
    always_comb begin
        load_val_d    = Sh_Load_Val;
        load_n_d      = 1'b1;
        shift_right_d = 1'b0;
        asr_d         = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        unique case (state_d)
            LOAD: begin
                load_n_d   = 1'b0;
                load_val_d = Load_Val;
                busy_d     = 1'b1;
            end
            SHIFT: begin
                shift_right_d = 1'b1;
                asr_d         = arith_q & Sh_Load_Val[WIDTH-1];
                busy_d        = 1'b1;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    // Output registers and command capture.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Sh_Load_Val   <= '0;
            Sh_Load_n     <= 1'b1;
            Sh_ShiftRight <= 1'b0;
            Sh_ASR        <= 1'b0;
            Busy          <= 1'b0;
            Done          <= 1'b0;
            rem_q         <= '0;
            arith_q       <= 1'b0;
        end else begin
            Sh_Load_Val   <= load_val_d;
            Sh_Load_n     <= load_n_d;
            Sh_ShiftRight <= shift_right_d;
            Sh_ASR        <= asr_d;
            Busy          <= busy_d;
            Done          <= done_d;
            if (start_acc) begin
                rem_q   <= count_sat;
                arith_q <= Arith;
            end else if (state_q == SHIFT) begin
                rem_q <= rem_q - CNT_ONE;
            end
        end
    end

`ifdef SHIFT_SEQ_SHADOW_CHECK_EN
    shift_seq_shadow #(
        .WIDTH (WIDTH)
    ) u_shadow (
        .clk         (Clk),
        .reset       (Reset),
        .load_n      (Sh_Load_n),
        .shift_right (Sh_ShiftRight),
        .fill        (Sh_ASR),
        .load_val    (Sh_Load_Val),
        .check       (Done),
        .clear       (start_acc),
        .sh_q        (Sh_Q),
        .mismatch    (Mismatch)
    );
`else
    // Feedback is only needed by the shadow check.
    logic unused_sh_q;
    assign unused_sh_q = ^Sh_Q;
    assign Mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Purpose: directed bench for shift_sequencer with a bench-side shifter and timeline model.
// Latency: model schedules LOAD at c+1, shifts at c+2..c+n+1, Done at c+n+2 for a start in cycle c.
// Backpressure: model accepts a start only when it expects the block to be idle or done.
module tb_shift_sequencer;

    localparam int NC = 512;

`ifdef SHIFT_SEQ_SHADOW_CHECK_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic [7:0] Load_Val = 8'h00;
    logic [3:0] Count = 4'd0;
    logic       Arith = 1'b0;
    logic [7:0] Sh_Q;
    logic [7:0] Sh_Load_Val;
    logic       Sh_Load_n, Sh_ShiftRight, Sh_ASR, Busy, Done, Mismatch;
    logic [3:0] Remaining;

    logic [7:0] shq = 8'h00;
    logic       corrupt = 1'b0;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    always #5 Clk = ~Clk;

    shift_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Load_Val(Load_Val),
        .Count(Count), .Arith(Arith), .Sh_Q(Sh_Q),
        .Sh_Load_Val(Sh_Load_Val), .Sh_Load_n(Sh_Load_n),
        .Sh_ShiftRight(Sh_ShiftRight), .Sh_ASR(Sh_ASR), .Busy(Busy),
        .Done(Done), .Remaining(Remaining), .Mismatch(Mismatch)
    );

    // The downstream 8-bit load/shift-right register.
    always @(posedge Clk) begin
        if (!Sh_Load_n)         shq <= Sh_Load_Val;
        else if (Sh_ShiftRight) shq <= {Sh_ASR, shq[7:1]};
    end
    assign Sh_Q = shq ^ {7'b0, corrupt};

    always @(posedge Clk) cyc <= cyc + 1;

    // Expected pin values per cycle.
    typedef struct {
        bit         ld_n, shr, asr, busy, done, mis, mis_set, ldv_chk;
        logic [7:0] ldv;
        logic [7:0] q;
        logic [3:0] rem;
    } exp_t;

    exp_t ex [NC];
    exp_t e;

    function automatic exp_t idle_e();
        exp_t r;
        r.ld_n = 1'b1; r.shr = 1'b0; r.asr = 1'b0; r.busy = 1'b0; r.done = 1'b0;
        r.mis = 1'b0; r.mis_set = 1'b0; r.ldv_chk = 1'b0;
        r.ldv = 8'h00; r.q = 8'h00; r.rem = 4'd0;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, want);
        end
    endtask

    // Reset sampled at the end of cycle r: everything after is idle with Load_Val cleared.
    task automatic model_reset(input int r);
        for (int t = r + 1; t < NC; t++) ex[t] = idle_e();
        if (r + 1 < NC) ex[r + 1].ldv_chk = 1'b1;
    endtask

    // Start accepted at the end of cycle c.
    task automatic model_accept(input int c, input logic [7:0] v, input logic [3:0] n_raw,
                                input bit a, input bit b);
        int               n;
        int               d;
        bit               keep;
        logic signed [7:0] sv;
        n    = (n_raw > 4'd8) ? 8 : int'(n_raw);
        d    = c + n + 2;
        sv   = v;
        keep = ex[c].done && ex[c].mis_set;
        for (int t = c + 1; t < NC; t++) ex[t].mis = keep;
        if (d >= NC) return;
        ex[c + 1].ld_n = 1'b0; ex[c + 1].ldv = v; ex[c + 1].ldv_chk = 1'b1;
        ex[c + 1].busy = 1'b1; ex[c + 1].rem = 4'(n);
        for (int k = 0; k < n; k++) begin
            ex[c + 2 + k].shr  = 1'b1;
            ex[c + 2 + k].asr  = a & v[7];
            ex[c + 2 + k].busy = 1'b1;
            ex[c + 2 + k].rem  = 4'(n - k);
        end
        ex[d].done = 1'b1;
        ex[d].q    = a ? 8'(sv >>> n) : (v >> n);
        if (b) begin
            ex[d].mis_set = 1'b1;
            for (int t = d + 1; t < NC; t++) ex[t].mis = 1'b1;
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge Clk) begin
        if (cyc >= 1 && cyc < NC) begin
            e = ex[cyc];
            chk("load_n",    8'(Sh_Load_n),     8'(e.ld_n));
            chk("shift",     8'(Sh_ShiftRight), 8'(e.shr));
            chk("asr",       8'(Sh_ASR),        8'(e.asr));
            chk("busy",      8'(Busy),          8'(e.busy));
            chk("done",      8'(Done),          8'(e.done));
            chk("remaining", 8'(Remaining),     8'(e.rem));
            chk("mismatch",  8'(Mismatch),      8'(e.mis));
            if (e.ldv_chk) chk("load_val", Sh_Load_Val, e.ldv);
            if (e.done)    chk("result",   shq,         e.q);
        end
    end

    task automatic issue(input logic [7:0] v, input logic [3:0] n, input bit a,
                         input bit b, output int c);
        c = cyc;
        Start = 1'b1; Load_Val = v; Count = n; Arith = a;
        if (!ex[c].busy) model_accept(c, v, n, a, b);
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic wait_done(input int c0, input int off, input logic [7:0] q, input string nm);
        int i;
        i = 0;
        while (!Done && i < 40) begin
            @(negedge Clk);
            i++;
        end
        if (!Done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout got=no_done want=done_at_%0d", nm, off);
        end else begin
            chk({nm, "_lat"}, 8'(cyc - c0), 8'(off));
            chk({nm, "_q"},   shq,          q);
        end
    endtask

    initial begin
        int c, c2;
        for (int t = 0; t < NC; t++) ex[t] = idle_e();
        for (int t = 1; t <= 3; t++) ex[t].ldv_chk = 1'b1;

        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        // Logical shift by 3.
        issue(8'h96, 4'd3, 1'b0, 1'b0, c);
        wait_done(c, 5, 8'h12, "lsr3");
        repeat (2) @(negedge Clk);

        // Arithmetic shift, negative operand; a stray Start during SHIFT is dropped.
        issue(8'h96, 4'd3, 1'b1, 1'b0, c);
        @(negedge Clk);
        issue(8'h01, 4'd1, 1'b0, 1'b0, c2);
        wait_done(c, 5, 8'hF2, "asr3");
        repeat (2) @(negedge Clk);

        // Arithmetic shift, positive operand: zero fill.
        issue(8'h56, 4'd3, 1'b1, 1'b0, c);
        wait_done(c, 5, 8'h0A, "asr3_pos");
        @(negedge Clk);

        // Zero count: straight from LOAD to DONE.
        issue(8'h96, 4'd0, 1'b0, 1'b0, c);
        wait_done(c, 2, 8'h96, "cnt0");
        @(negedge Clk);

        // Saturating count.
        issue(8'h96, 4'd12, 1'b1, 1'b0, c);
        wait_done(c, 10, 8'hFF, "sat12");
        @(negedge Clk);
        issue(8'hB4, 4'd15, 1'b0, 1'b0, c);
        wait_done(c, 10, 8'h00, "sat15");
        @(negedge Clk);

        // Back-to-back: Start held during DONE.
        issue(8'h96, 4'd3, 1'b0, 1'b0, c);
        wait_done(c, 5, 8'h12, "b2b_a");
        issue(8'hC3, 4'd2, 1'b1, 1'b0, c);
        wait_done(c, 4, 8'hF0, "b2b_b");
        repeat (2) @(negedge Clk);

        // Reset in cycle 3 of a Count=5 command, then a normal command.
        issue(8'h80, 4'd5, 1'b1, 1'b0, c);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        model_reset(cyc);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        issue(8'h7F, 4'd4, 1'b0, 1'b0, c);
        wait_done(c, 6, 8'h07, "after_rst");
        repeat (2) @(negedge Clk);

        // Shifter feedback disturbed during DONE, then a clean command.
        corrupt = 1'b1;
        issue(8'h96, 4'd3, 1'b0, SHADOW, c);
        wait_done(c, 5, 8'h12, "shadow_bad");
        @(negedge Clk);
        corrupt = 1'b0;
        repeat (3) @(negedge Clk);
        issue(8'h96, 4'd3, 1'b0, 1'b0, c);
        wait_done(c, 5, 8'h12, "shadow_ok");
        repeat (4) @(negedge Clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
